// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
package imem_loader_pkg;
  localparam int LEN_W = 16;
  localparam int HDR_BYTES = 2;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR} state_t;
endpackage

// File: rtl/imem_loader_csum.sv
// loader_csum: 8-bit running sum of payload bytes, used only with IMEM_LOADER_CSUM_EN.
`ifdef IMEM_LOADER_CSUM_EN
module loader_csum (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] sum
);
  always_ff @(posedge clock)
    if (!reset || clear) sum <= '0;
    else if (en) sum <= sum + data;
endmodule
`endif

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte image loader into instruction memory; owns cpu run/hold.
// Define IMEM_LOADER_CSUM_EN to require a trailing checksum byte after the payload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);
  state_t state, nxt;
  logic [HDR_BYTES*8-1:0] len;
  logic [LEN_W-1:0] cnt, hdr_len;
  logic xfer, load;
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t POST = CSUM;
  logic [7:0] sum;
  loader_csum u_csum (
    .clock(clock),
    .reset(reset),
    .clear(load),
    .en(xfer && state == DATA),
    .data(in_byte),
    .sum(sum)
  );
`else
  localparam state_t POST = RUN;
`endif
  assign in_ready = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign busy = in_ready;
  assign cpu_run = state == RUN;
  assign error = state == ERR;
  assign xfer = in_valid && in_ready;
  assign load = start && state inside {IDLE, RUN, ERR};
  assign hdr_len = {in_byte, len[7:0]};
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? LEN_LO : IDLE;
      LEN_LO:   nxt = xfer ? LEN_HI : LEN_LO;
      LEN_HI:   if (xfer) nxt = hdr_len > LEN_W'(MEM_BYTES) ? ERR : hdr_len == '0 ? POST : DATA;
      DATA:     if (xfer && cnt == len - 1'b1) nxt = POST;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:     if (xfer) nxt = in_byte == sum ? RUN : ERR;
`endif
      RUN, ERR: nxt = start ? LEN_LO : state;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      len <= '0;
      cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= xfer && state == DATA;
      if (load) cnt <= '0;
      if (xfer && state == LEN_LO) len[7:0] <= in_byte;
      if (xfer && state == LEN_HI) len <= hdr_len;
      if (xfer && state == DATA) begin
        mem_addr <= cnt[ADDR_W-1:0];
        mem_wdata <= in_byte;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader upstream of the processor's FETCH stage. Accepts a length-prefixed byte image over a valid/ready link, writes it byte-by-byte into the 8-bit instruction memory that FETCH reads, and holds the processor in reset until the image is complete. Sits between the host/boot link and the processor top, and owns the processor's run/hold control.

## Interface
- MEM_BYTES, 64: instruction memory depth in bytes; maximum accepted image length.
- ADDR_W, 6: memory address width; must satisfy 2**ADDR_W >= MEM_BYTES.
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new load.
- in_valid  in  1  in_byte is valid this cycle.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte to write.
- cpu_run  out  1  1 releases the processor; 0 holds it in reset.
- busy  out  1  load in progress.
- error  out  1  sticky load failure flag.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR.
- Transfer occurs on any cycle with in_valid && in_ready. in_ready = 1 only in LEN_LO, LEN_HI, DATA, and CSUM. Bytes offered in other states are ignored and not consumed.
- IDLE: on start, go to LEN_LO. Clear the byte counter, the address, and the checksum.
- LEN_LO/LEN_HI: capture a 16-bit length, little-endian.
  - After LEN_HI, if length > MEM_BYTES: go to ERR.
  - If length == 0: go to CSUM (or RUN without checksum).
  - Otherwise: go to DATA.
- DATA: each transferred byte is written to address = counter; the counter increments. After the byte at counter == length-1, go to CSUM (or RUN).
- CSUM: the received byte is compared to the 8-bit sum mod 256 of all payload bytes.
  - Match: go to RUN.
  - Mismatch: go to ERR.
- RUN: cpu_run = 1. start causes cpu_run = 0 on the next cycle and goes to LEN_LO. This reload path also clears error.
- ERR: error = 1, cpu_run = 0. start clears error and goes to LEN_LO.
- start in LEN_LO/LEN_HI/DATA/CSUM is ignored.
- Address arithmetic: the counter is 16 bits; mem_addr is counter[ADDR_W-1:0]. No wrap can occur because length <= MEM_BYTES.

## Timing
- Reset values: state = IDLE; in_ready, mem_we, cpu_run, busy, and error = 0; mem_addr and mem_wdata = 0.
- Write latency is 1 cycle. mem_we, mem_addr, and mem_wdata are registered and asserted for exactly the cycle after a DATA transfer. Back-to-back transfers give back-to-back writes.
- cpu_run rises the cycle after the final accepted byte (checksum, or last payload byte).
- busy = 1 in LEN_LO, LEN_HI, DATA, and CSUM.
- error rises the cycle after the offending transfer.
- Reset mid-load returns to IDLE on the next edge:
  - cpu_run stays 0.
  - A pending mem_we is dropped.
  - Partially written memory contents are not cleared.

## Configuration
- IMEM_LOADER_CSUM_EN defined: the CSUM state exists; one checksum byte follows the payload; a mismatch gives ERR.
- IMEM_LOADER_CSUM_EN undefined:
  - No CSUM state or accumulator.
  - DATA (or length == 0) goes directly to RUN.
  - error can only be caused by the length check.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum typedef;
  - the LEN_W = 16 constant;
  - the header byte count constant (2).
- One sub-module, loader_csum: an 8-bit accumulator with clear and enable inputs and sum output. It is instantiated only under IMEM_LOADER_CSUM_EN.

## Test plan
- Load 3 bytes: start, then 03 00 AA BB CC, then checksum 31.
  - Writes: addr 0/1/2 = AA/BB/CC.
  - cpu_run = 1 the cycle after 31.
  - error = 0.
- Same image with checksum 00:
  - Three writes still occur.
  - error = 1 and cpu_run = 0.
  - A subsequent start clears error.
- Length over limit: header 41 00 (65 > MEM_BYTES 64).
  - ERR immediately.
  - No mem_we.
  - in_ready = 0 afterwards.
- Zero length: header 00 00, then checksum 00.
  - RUN with no writes.
- Stalls and reset:
  - in_valid toggled 1/0 during DATA: each write is 1 cycle after its transfer, with addresses contiguous.
  - reset low after 2 payload bytes: IDLE, busy = 0, cpu_run = 0 next cycle.
- Reload from RUN: start pulse.
  - cpu_run falls the next cycle.
  - The new image is written from address 0.
